// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with flush; read data shows the head entry combinationally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential fetch into a small FIFO, with redirect flush and drain.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state, state_next;
    logic [31:0]   fpc, fpc_next;
    logic [31:0]   tgt, tgt_next;
    logic [31:0]   redirect_addr;
    logic [CW-1:0] cnt;
    logic          push, pop, flush;
    fetch_entry_t  wr_entry, rd_entry;
    logic          unused_redirect_lsbs;

    assign redirect_addr        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            fpc   <= {RESET_PC[31:2], 2'b00};
            tgt   <= {RESET_PC[31:2], 2'b00};
        end else begin
            state <= state_next;
            fpc   <= fpc_next;
            tgt   <= tgt_next;
        end
    end

    // A redirect against an outstanding unacked request must wait for that ack in DRAIN.
    always_comb begin
        state_next = state;
        fpc_next   = fpc;
        tgt_next   = tgt;
        if (redirect_valid) begin
            if (imem_req && !imem_ack) begin
                tgt_next   = redirect_addr;
                state_next = DRAIN;
            end else begin
                fpc_next   = redirect_addr;
                state_next = FETCH;
            end
        end else if (imem_req && imem_ack) begin
            if (state == DRAIN) begin
                fpc_next   = tgt;
                state_next = FETCH;
            end else begin
                fpc_next = fpc + PC_INC;
            end
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if (!rst) imem_req = (state == DRAIN) || (cnt < CW'(DEPTH));
        imem_addr   = {fpc[31:2], 2'b00};
        push        = !rst && (state == FETCH) && imem_req && imem_ack && !redirect_valid;
        if_valid    = !rst && (cnt != '0);
        pop         = if_valid && !if_stall && !redirect_valid;
        flush       = redirect_valid;
        wr_entry    = '{instr: imem_rdata, pc_plus4: imem_addr + PC_INC};
        if_instr    = if_valid ? rd_entry.instr    : '0;
        if_pc_plus4 = if_valid ? rd_entry.pc_plus4 : '0;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (cnt)
    );

endmodule
